// File: rtl/sfr_sel_pkg.sv
// Shared types and default widths for the SFR write-select stage.
// Optional build macro used elsewhere: SFR_SEL_ONEHOT_CHECK_EN.
package sfr_sel_pkg;

   localparam int SFR_DATA_WIDTH = 8;
   localparam int SFR_NUM_SRC    = 3;
   localparam int SFR_ADDR_WIDTH = 4;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b11
   } skid_state_e;

   // True when exactly one bit of the (zero-extended) select vector is set.
   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/sfr_write_sel_if.sv
// Request/response bundle between the memory stage and the SFR write-select stage.
interface sfr_write_sel_if import sfr_sel_pkg::*; #(
   parameter int DATA_WIDTH = SFR_DATA_WIDTH,
   parameter int NUM_SRC    = SFR_NUM_SRC,
   parameter int ADDR_WIDTH = SFR_ADDR_WIDTH
) ();

   logic [NUM_SRC-1:0]            src_sel;
   logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
   logic [ADDR_WIDTH-1:0]         in_addr;
   logic                          in_valid;
   logic                          in_ready;
   logic                          out_valid;
   logic                          out_ready;
   logic [DATA_WIDTH-1:0]         out_data;
   logic [ADDR_WIDTH-1:0]         out_addr;
   logic                          sel_err;
   logic                          err_clr;

   modport master (
      output src_sel, src_data, in_addr, in_valid, out_ready, err_clr,
      input  in_ready, out_valid, out_data, out_addr, sel_err
   );

   modport slave (
      input  src_sel, src_data, in_addr, in_valid, out_ready, err_clr,
      output in_ready, out_valid, out_data, out_addr, sel_err
   );

endinterface

// File: rtl/sfr_skid_buffer.sv
// Two-entry skid buffer: main register drives the outputs, skid register
// absorbs one extra request while the consumer stalls. in_ready is registered.
module sfr_skid_buffer import sfr_sel_pkg::*; #(
   parameter int WIDTH = SFR_DATA_WIDTH + SFR_ADDR_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_payload,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_payload
);

   skid_state_e      state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             accept_s;

   assign accept_s    = in_valid && in_ready_q;
   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_payload = main_q;

   // Next-state, storage and handshake-flag computation.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept_s) begin
               main_d  = in_payload;
               state_d = ONE;
            end else begin
               state_d = EMPTY;
            end
         end
         ONE: begin
            if (accept_s && out_ready) begin
               main_d = in_payload;
            end else if (accept_s) begin
               skid_d  = in_payload;
               state_d = FULL;
            end else if (out_ready) begin
               state_d = EMPTY;
            end else begin
               state_d = ONE;
            end
         end
         FULL: begin
            // accept_s is impossible here because in_ready_q is low.
            if (out_ready) begin
               main_d  = skid_q;
               state_d = ONE;
            end else begin
               state_d = FULL;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   // State and storage registers; reset discards both entries.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= EMPTY;
         main_q      <= {WIDTH{1'b0}};
         skid_q      <= {WIDTH{1'b0}};
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: rtl/sfr_write_sel.sv
// SFR write-data source select with registered valid/ready output stage.
// SFR_SEL_ONEHOT_CHECK_EN: priority select plus live sel_err; otherwise AND-OR mux.
module sfr_write_sel import sfr_sel_pkg::*; #(
   parameter int DATA_WIDTH = SFR_DATA_WIDTH,
   parameter int NUM_SRC    = SFR_NUM_SRC,
   parameter int ADDR_WIDTH = SFR_ADDR_WIDTH
) (
   input  logic            clock,
   input  logic            reset_n,
   sfr_write_sel_if.slave  bus
);

   localparam int PW = DATA_WIDTH + ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] sel_data_s;
   logic [PW-1:0]         out_payload_s;

`ifdef SFR_SEL_ONEHOT_CHECK_EN
   logic        found_s;
   logic        accept_s;
   logic [31:0] sel_ext_s;
   logic        sel_err_q, sel_err_d;

   // Lowest-index asserted select wins.
   always_comb begin
      sel_data_s = {DATA_WIDTH{1'b0}};
      found_s    = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (bus.src_sel[i] && !found_s) begin
            sel_data_s = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
            found_s    = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign accept_s = bus.in_valid && bus.in_ready;

   // Sticky select-error flag; a new error outranks a simultaneous clear.
   always_comb begin
      sel_ext_s                = 32'd0;
      sel_ext_s[NUM_SRC-1:0]   = bus.src_sel;
      if (accept_s && !is_onehot(sel_ext_s)) begin
         sel_err_d = 1'b1;
      end else if (bus.err_clr) begin
         sel_err_d = 1'b0;
      end else begin
         sel_err_d = sel_err_q;
      end
   end

   // sel_err register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= sel_err_d;
      end
   end

   assign bus.sel_err = sel_err_q;
`else
   logic unused_err_clr_s;

   // Legacy AND-OR mux: every selected source is ORed in.
   always_comb begin
      sel_data_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
         if (bus.src_sel[i]) begin
            sel_data_s = sel_data_s | bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
   end

   assign unused_err_clr_s = bus.err_clr;
   assign bus.sel_err      = 1'b0;
`endif

   sfr_skid_buffer #(
      .WIDTH (PW)
   ) u_skid (
      .clock       (clock),
      .reset_n     (reset_n),
      .in_valid    (bus.in_valid),
      .in_ready    (bus.in_ready),
      .in_payload  ({sel_data_s, bus.in_addr}),
      .out_valid   (bus.out_valid),
      .out_ready   (bus.out_ready),
      .out_payload (out_payload_s)
   );

   assign bus.out_data = out_payload_s[ADDR_WIDTH +: DATA_WIDTH];
   assign bus.out_addr = out_payload_s[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_sfr_write_sel.sv
// Directed self-checking bench for sfr_write_sel; expectations follow
// SFR_SEL_ONEHOT_CHECK_EN when it is defined for the build.
module tb_sfr_write_sel;

   logic clock;
   logic reset_n;
   int   n_checks;
   int   n_fail;

   sfr_write_sel_if #(.DATA_WIDTH(8), .NUM_SRC(3), .ADDR_WIDTH(4)) bus ();

   sfr_write_sel #(.DATA_WIDTH(8), .NUM_SRC(3), .ADDR_WIDTH(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic req(input logic [2:0] sel, input logic [23:0] data, input logic [3:0] addr);
      bus.in_valid = 1'b1;
      bus.src_sel  = sel;
      bus.src_data = data;
      bus.in_addr  = addr;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset_n      = 1'b0;
      bus.in_valid = 1'b0;
      bus.src_sel  = 3'b000;
      bus.src_data = 24'h000000;
      bus.in_addr  = 4'h0;
      bus.out_ready = 1'b0;
      bus.err_clr  = 1'b0;
      #12;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data",  32'(bus.out_data),  32'd0);
      check("rst_out_addr",  32'(bus.out_addr),  32'd0);
      check("rst_sel_err",   32'(bus.sel_err),   32'd0);
      check("rst_in_ready",  32'(bus.in_ready),  32'd1);
      reset_n = 1'b1;
      tick();

      // Basic single transfer from source 1.
      bus.out_ready = 1'b1;
      req(3'b010, 24'h00A500, 4'h3);
      tick();
      bus.in_valid = 1'b0;
      check("basic_valid",   32'(bus.out_valid), 32'd1);
      check("basic_data",    32'(bus.out_data),  32'hA5);
      check("basic_addr",    32'(bus.out_addr),  32'h3);
      check("basic_sel_err", 32'(bus.sel_err),   32'd0);
      tick();
      check("basic_drain", 32'(bus.out_valid), 32'd0);

      // Back-pressure: third request must wait until the skid entry frees.
      bus.out_ready = 1'b0;
      req(3'b001, 24'h000011, 4'h1);
      tick();
      check("bp_first_data", 32'(bus.out_data), 32'h11);
      check("bp_ready_one",  32'(bus.in_ready), 32'd1);
      req(3'b001, 24'h000022, 4'h2);
      tick();
      check("bp_full_ready", 32'(bus.in_ready), 32'd0);
      req(3'b001, 24'h000033, 4'h3);
      tick();
      check("bp_hold_data",  32'(bus.out_data), 32'h11);
      check("bp_hold_addr",  32'(bus.out_addr), 32'h1);
      check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("bp_hold2_data", 32'(bus.out_data), 32'h11);
      bus.out_ready = 1'b1;
      tick();
      check("bp_pop2_data",  32'(bus.out_data),  32'h22);
      check("bp_pop2_addr",  32'(bus.out_addr),  32'h2);
      check("bp_pop2_valid", 32'(bus.out_valid), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      check("bp_pop3_data", 32'(bus.out_data), 32'h33);
      check("bp_pop3_addr", 32'(bus.out_addr), 32'h3);
      tick();
      check("bp_empty", 32'(bus.out_valid), 32'd0);

      // Multi-hot select on sources 1 and 2.
      req(3'b110, 24'hF00F00, 4'h5);
      tick();
      bus.in_valid = 1'b0;
`ifdef SFR_SEL_ONEHOT_CHECK_EN
      check("multi_data",    32'(bus.out_data), 32'h0F);
      check("multi_sel_err", 32'(bus.sel_err),  32'd1);
`else
      check("multi_data",    32'(bus.out_data), 32'hFF);
      check("multi_sel_err", 32'(bus.sel_err),  32'd0);
`endif
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      check("clr_sel_err", 32'(bus.sel_err), 32'd0);

      // Error and clear in the same cycle: the error wins.
      req(3'b011, 24'h000201, 4'h6);
      bus.err_clr = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.err_clr  = 1'b0;
`ifdef SFR_SEL_ONEHOT_CHECK_EN
      check("setwin_sel_err", 32'(bus.sel_err),  32'd1);
      check("setwin_data",    32'(bus.out_data), 32'h01);
`else
      check("setwin_sel_err", 32'(bus.sel_err),  32'd0);
      check("setwin_data",    32'(bus.out_data), 32'h03);
`endif
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;

      // Zero-hot select yields zero data.
      req(3'b000, 24'h5A5A5A, 4'h7);
      tick();
      bus.in_valid = 1'b0;
      check("zero_data", 32'(bus.out_data), 32'h00);
      check("zero_addr", 32'(bus.out_addr), 32'h7);
`ifdef SFR_SEL_ONEHOT_CHECK_EN
      check("zero_sel_err", 32'(bus.sel_err), 32'd1);
`else
      check("zero_sel_err", 32'(bus.sel_err), 32'd0);
`endif
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;

      // Streaming from source 2, one result per cycle.
      for (int i = 0; i < 4; i++) begin
         req(3'b100, {8'(8'h40 + i), 16'h0000}, 4'(i + 8));
         tick();
         check("stream_data",  32'(bus.out_data),  32'h40 + 32'(i));
         check("stream_addr",  32'(bus.out_addr),  32'(i + 8));
         check("stream_ready", 32'(bus.in_ready),  32'd1);
      end
      bus.in_valid = 1'b0;
      tick();

      // Reset while FULL drops everything at once.
      bus.out_ready = 1'b0;
      req(3'b001, 24'h0000AA, 4'hA);
      tick();
      req(3'b001, 24'h0000BB, 4'hB);
      tick();
      bus.in_valid = 1'b0;
      check("full_before_rst", 32'(bus.in_ready), 32'd0);
      reset_n = 1'b0;
      #1;
      check("rst_full_valid", 32'(bus.out_valid), 32'd0);
      check("rst_full_ready", 32'(bus.in_ready),  32'd1);
      check("rst_full_data",  32'(bus.out_data),  32'd0);
      #2;
      reset_n = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      check("post_rst_valid", 32'(bus.out_valid), 32'd0);
      req(3'b001, 24'h0000CC, 4'hC);
      tick();
      bus.in_valid = 1'b0;
      check("post_rst_data", 32'(bus.out_data), 32'hCC);
      tick();
      check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sfr_write_sel.md
# sfr_write_sel

Parametrised, registered source-select stage for special function register (SFR) write data in the memory stage. It chooses one of NUM_SRC forwarded data sources (EX/MEM bottom byte, MEM/WB top byte, MEM/WB bottom byte, and further sources), tags the result with its SFR address, and presents it to the SFR file through a valid/ready handshake. A two-entry skid buffer decouples the pipeline from SFR file back-pressure.

## Interface
- DATA_WIDTH, 8, width of each source and of the output data
- NUM_SRC, 3, number of selectable sources; source 0 has highest priority
- ADDR_WIDTH, 4, width of the SFR address carried with the data
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- src_sel  in  NUM_SRC  per-source select; bit i selects source i
- src_data  in  NUM_SRC*DATA_WIDTH  flattened sources; source i is bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_addr  in  ADDR_WIDTH  target SFR address
- in_valid  in  1  request valid
- in_ready  out  1  stage can accept; equals "skid entry empty"
- out_valid  out  1  output entry valid
- out_ready  in  1  SFR file accepts output
- out_data  out  DATA_WIDTH  selected data
- out_addr  out  ADDR_WIDTH  address of out_data
- sel_err  out  1  sticky: multi-hot or zero-hot select seen on an accepted request
- err_clr  in  1  synchronous clear of sel_err

## Operation
- Accept occurs when in_valid && in_ready. Only accepted requests are sampled.
- Data resolution depends on SFR_SEL_ONEHOT_CHECK_EN (see Configuration). Zero-hot src_sel yields data 0.
- Storage is one main register (drives outputs) and one skid register. States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
- EMPTY: accept → main loads, go to ONE.
- ONE: accept with out_ready → main reloads, stay in ONE. Accept without out_ready → skid loads, go to FULL. out_ready without accept → EMPTY.
- FULL: in_ready=0. out_ready → main takes skid, go to ONE. Otherwise hold.
- Order is strictly FIFO. Nothing is dropped or duplicated.
- sel_err set on accept when popcount(src_sel) ≠ 1. Clear on err_clr. When set and clear occur in the same cycle, set wins.

## Timing
- Reset values: out_valid=0, out_data=0, out_addr=0, sel_err=0, state EMPTY, in_ready=1.
- Latency: accept in cycle N gives out_valid=1 with that data in cycle N+1.
- Throughput: 1 per cycle while out_ready stays high.
- out_data and out_addr are stable while out_valid && !out_ready.
- in_ready is a register output. It has no combinational path from out_ready.
- Reset asserted mid-transfer discards both entries immediately, with no handshake completion.

## Configuration
- Macro SFR_SEL_ONEHOT_CHECK_EN.
- Defined:
  - Priority resolution: the lowest-index asserted select wins.
  - sel_err is live.
- Undefined (legacy AND-OR mux behaviour):
  - out_data is the bitwise OR of all selected sources.
  - sel_err is tied 0 and err_clr is ignored.

## Structure
- Package sfr_sel_pkg holds:
  - the state typedef/localparams: EMPTY=2'b00, ONE=2'b01, FULL=2'b11
  - default width constants
- Sub-module sfr_skid_buffer, parametrised on DATA_WIDTH+ADDR_WIDTH, holds the state machine and the two registers.
- The top level holds source resolution and the sel_err logic.

## Test plan
- Reset, then in_valid=1, src_sel=3'b010, source 1=8'hA5, addr=4'h3, out_ready=1 → next cycle out_valid=1, out_data=8'hA5, out_addr=4'h3, sel_err=0.
- Back-pressure: out_ready=0, three back-to-back requests 8'h11, 8'h22, 8'h33 → 8'h11 and 8'h22 accepted, in_ready=0 after the second, 8'h33 held. Release out_ready → outputs 8'h11, 8'h22, 8'h33 in order.
- Multi-hot, macro defined: src_sel=3'b110, sources 1 and 2 = 8'h0F and 8'hF0 → out_data=8'h0F, sel_err=1 next cycle. err_clr pulse → sel_err=0.
- Multi-hot, macro undefined: same stimulus → out_data=8'hFF, sel_err=0.
- Zero-hot select with in_valid=1 → out_data=8'h00. sel_err=1 when the macro is defined.
- Assert reset_n=0 while in the FULL state → out_valid=0, in_ready=1 immediately. After release, no stale data appears.
